serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Transmit end of the lab serial link: takes a parallel word, frames it (start bit, data LSB-first, stop bit) and drives a single registered serial line.
- Pairs with the DFF-sampled serial receiver; the line idles high.
- Sits between a parallel producer (valid/ready handshake) and the off-block serial wire.

Parameters:
- WIDTH, 8, data bits per frame (1..16).
- DIV, 4, clock cycles per serial bit (>=1; DIV=1 is legal).

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  WIDTH  parallel word; sampled only on an accepted load.
- LOAD  input  1  producer valid.
- READY  output  1  high only in IDLE; a load is accepted at a rising edge where LOAD&&READY.
- SOUT  output  1  serial line, driven directly from a flop.
- BUSY  output  1  high while a frame is in progress (START, DATA or STOP).
- DONE  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (RST high at an edge): state=IDLE; SOUT=1, READY=1, BUSY=0, DONE=0; bit counter and divider cleared; shift register contents don't-care.
- RST mid-frame aborts at the next edge: the line returns high and the word is discarded, with no DONE.
- States are IDLE, START, DATA and STOP.
- IDLE: SOUT=1, READY=1. On LOAD&&READY at edge k: latch DIN into the shift register and enter START. From edge k, SOUT=0, READY=0, BUSY=1.
- Every serial bit lasts exactly DIV cycles. A divider counts 0..DIV-1, and a bit boundary occurs at the edge where divider==DIV-1.
- START: SOUT=0 for DIV cycles, then DATA with bit index 0.
- DATA: SOUT=shift[0]. At each bit boundary, shift right and increment the index. After bit WIDTH-1 ends, enter STOP.
- STOP: SOUT=1 for DIV cycles. DONE=1 during the final cycle, when divider==DIV-1. At that boundary edge, enter IDLE, with READY=1 and BUSY=0 from that edge.
- Frame length is exactly (WIDTH+2)*DIV cycles from the accept edge to the IDLE edge.
- LOAD while not READY (including the DONE cycle) is ignored. There is no queueing, and DIN changes mid-frame have no effect.
- Back-to-back operation: if LOAD is high in the first IDLE cycle, the next START begins one cycle after the previous frame's IDLE edge. SOUT is 1 for exactly one cycle between frames.
- All outputs are registered or decoded from registered state only; there is no combinational path from LOAD or DIN to any output.
- Counter widths: the divider uses clog2(DIV) bits (min 1) and the bit index uses clog2(WIDTH+1) bits. Neither counter wraps outside its state.

Decomposition:
- Shared package serial_pkg:
  - state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
  - line idle level constant (1'b1)
  - these are reused by the receiver.
- One natural sub-module, bit_timer:
  - parameter DIV; inputs CLK, RST, clear, enable; output tick.
  - tick is high on the cycle where the count equals DIV-1, and the count wraps to 0 after that cycle.
  - instantiated once and cleared on frame accept.

Test Plan:
- Reset/idle: RST high for 2 cycles, then LOAD=0 for 20 cycles -> SOUT=1, READY=1, BUSY=0, DONE=0 throughout.
- Single frame: WIDTH=8, DIV=4, DIN=8'hA5, LOAD pulsed 1 cycle -> SOUT holds 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles (40 cycles total); DONE high only in cycle 40; READY returns 1 at edge 40.
- Ignored load: during the frame above, pulse LOAD with DIN=8'hFF in cycles 10 and 40 (the DONE cycle) -> no change to the bit sequence, no second frame.
- Back-to-back: LOAD held high with DIN=8'h01 then 8'h80 -> two 40-cycle frames separated by exactly 1 idle-high cycle; data bits are 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Mid-frame reset: assert RST for 1 cycle at cycle 17 of an 8'h3C frame -> SOUT=1, BUSY=0, READY=1 at the next edge; no DONE; a following load of 8'h55 transmits correctly.
- DIV=1, WIDTH=4, DIN=4'b1001 -> SOUT sequence 0,1,0,0,1,1 on consecutive cycles; DONE in cycle 6.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: FSM state encoding and line idle level,
// common to the transmitter and the DFF-sampled receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Serial bit-period divider: tick marks the last cycle of each DIV-cycle bit.
module bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  // Wraps to zero right after the tick cycle so the next bit starts clean.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// each DIV cycles long, on a registered line that idles high.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned IDXW = $clog2(WIDTH + 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic [IDXW-1:0]  idx, idx_d;
  logic             sout_d;
  logic             tick;
  logic             accept_c;

  assign accept_c = (state == IDLE) && LOAD;

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (accept_c),
    .enable (state != IDLE),
    .tick   (tick)
  );

  // Status outputs decode registered state only; no path from LOAD or DIN.
  assign READY = (state == IDLE);
  assign BUSY  = (state != IDLE);
  assign DONE  = (state == STOP) && tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      SOUT  <= LINE_IDLE;
    end else begin
      state <= state_d;
      shift <= shift_d;
      idx   <= idx_d;
      SOUT  <= sout_d;
    end
  end

  // Next-state logic; sout_d is the line level for the state being entered.
  always_comb begin
    state_d = state;
    shift_d = shift;
    idx_d   = idx;
    sout_d  = SOUT;
    case (state)
      IDLE: begin
        sout_d = LINE_IDLE;
        if (LOAD) begin
          state_d = START;
          shift_d = DIN;
          idx_d   = '0;
          sout_d  = ~LINE_IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          sout_d  = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift >> 1;
          if (idx == IDXW'(WIDTH - 1)) begin
            state_d = STOP;
            sout_d  = LINE_IDLE;
          end else begin
            idx_d  = idx + IDXW'(1);
            sout_d = shift_d[0];
          end
        end
      end
      STOP: begin
        sout_d = LINE_IDLE;
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: directed plus random frames on an
// 8-bit/DIV=4 instance and a 4-bit/DIV=1 instance, against a slot-based model.
module tb_serial_frame_tx;

  localparam int unsigned WA = 8;
  localparam int unsigned DA = 4;
  localparam int unsigned WB = 4;
  localparam int unsigned DB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [WA-1:0] din_a;
  logic          load_a, ready_a, sout_a, busy_a, done_a;
  logic [WB-1:0] din_b;
  logic          load_b, ready_b, sout_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(WA), .DIV(DA)) dut_a (
    .CLK(clk), .RST(rst), .DIN(din_a), .LOAD(load_a),
    .READY(ready_a), .SOUT(sout_a), .BUSY(busy_a), .DONE(done_a)
  );

  serial_frame_tx #(.WIDTH(WB), .DIV(DB)) dut_b (
    .CLK(clk), .RST(rst), .DIN(din_b), .LOAD(load_b),
    .READY(ready_b), .SOUT(sout_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Line level in frame cycle c (1-based): slot 0 start, slots 1..w data LSB-first, then stop.
  function automatic logic model_bit(input logic [15:0] d, input int w, input int div, input int c);
    int slot;
    slot = (c - 1) / div;
    if (slot == 0) return 1'b0;
    if (slot <= w) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic s, input logic r, input logic b, input logic d);
    chk({tag, ".sout"},  sout_a,  s);
    chk({tag, ".ready"}, ready_a, r);
    chk({tag, ".busy"},  busy_a,  b);
    chk({tag, ".done"},  done_a,  d);
  endtask

  task automatic chk_b(input string tag, input logic s, input logic r, input logic b, input logic d);
    chk({tag, ".sout"},  sout_b,  s);
    chk({tag, ".ready"}, ready_b, r);
    chk({tag, ".busy"},  busy_b,  b);
    chk({tag, ".done"},  done_b,  d);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk_a($sformatf("%s.a%0d", tag, i), 1'b1, 1'b1, 1'b0, 1'b0);
      chk_b($sformatf("%s.b%0d", tag, i), 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after an edge; the accept happens at the next edge.
  task automatic frame_a(input logic [WA-1:0] d, input int ign1, input int ign2,
                         input bit hold, input logic [WA-1:0] nd, input int abort_at);
    int n;
    n = (WA + 2) * DA;
    din_a  = d;
    load_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= n; c++) begin
      chk_a($sformatf("a.%02h.c%0d", d, c), model_bit(16'(d), WA, DA, c), 1'b0, 1'b1, 1'(c == n));
      if (c == abort_at) begin
        rst    = 1'b1;
        load_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_a($sformatf("a.%02h.abort", d), 1'b1, 1'b1, 1'b0, 1'b0);
        return;
      end
      if (hold) begin
        load_a = 1'b1;
        din_a  = (c >= 5) ? nd : d;
      end else begin
        load_a = (c == ign1) || (c == ign2);
        din_a  = load_a ? 8'hFF : 8'($urandom);
      end
      @(posedge clk); #1;
    end
    chk_a($sformatf("a.%02h.end", d), 1'b1, 1'b1, 1'b0, 1'b0);
    if (!hold) load_a = 1'b0;
  endtask

  task automatic frame_b(input logic [WB-1:0] d);
    int n;
    n = (WB + 2) * DB;
    din_b  = d;
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    for (int c = 1; c <= n; c++) begin
      chk_b($sformatf("b.%01h.c%0d", d, c), model_bit(16'(d), WB, DB, c), 1'b0, 1'b1, 1'(c == n));
      din_b = 4'($urandom);
      @(posedge clk); #1;
    end
    chk_b($sformatf("b.%01h.end", d), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    load_a = 1'b0;
    din_a  = '0;
    load_b = 1'b0;
    din_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(20, "reset");

    frame_a(8'hA5, 10, 40, 1'b0, 8'h00, 0);
    idle_cycles(3, "after_a5");

    frame_a(8'h01, 0, 0, 1'b1, 8'h80, 0);
    frame_a(8'h80, 0, 0, 1'b0, 8'h00, 0);
    idle_cycles(2, "after_b2b");

    frame_a(8'h3C, 0, 0, 1'b0, 8'h00, 17);
    idle_cycles(3, "after_abort");
    frame_a(8'h55, 0, 0, 1'b0, 8'h00, 0);
    idle_cycles(1, "after_55");

    frame_b(4'b1001);
    idle_cycles(2, "after_b9");

    repeat (6) begin
      frame_a(8'($urandom), int'($urandom_range(1, 40)), 0, 1'b0, 8'h00, 0);
      idle_cycles(1, "rand_a");
    end
    repeat (8) begin
      frame_b(4'($urandom));
    end
    idle_cycles(2, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
